// File: rtl/alu_mult_sequencer.sv
// alu_mult_sequencer
//   Multi-cycle unsigned 32x32 -> 64 multiplier controller. Uses the shared
//   32-bit ripple ALU as its only adder: one add/shift-right step per clock,
//   32 steps per multiply.
//
// Ports
//   clk, rst_n         clock, synchronous active-low reset
//   start              request a multiply (accepted only while busy=0)
//   multiplicand       operand A, sampled on the accepting edge
//   multiplier         operand B, sampled on the accepting edge
//   busy               high while iterations are in progress
//   done               one-cycle pulse when product is valid
//   product            64-bit result, held until the next accepted start
//   alu_a/alu_b        ALU operand drive
//   alu_cin            ALU carry-in (tied 0)
//   alu_cless_than     ALU compare control (tied 0)
//   alu_op             ALU opcode (fixed to add)
//   alu_r/alu_cout     ALU sum and carry-out
module alu_mult_sequencer #(
  parameter logic [2:0]  ALU_OP_ADD = 3'b010,
  parameter int unsigned ITERATIONS = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] multiplicand,
  input  logic [31:0] multiplier,
  output logic        busy,
  output logic        done,
  output logic [63:0] product,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic        alu_cin,
  output logic        alu_cless_than,
  output logic [2:0]  alu_op,
  input  logic [31:0] alu_r,
  input  logic        alu_cout
);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  localparam logic [4:0] LAST_CNT = 5'(ITERATIONS - 1);

  state_t      state_q, state_d;
  logic [31:0] p_hi_q, p_lo_q, mcand_q;
  logic [4:0]  cnt_q;
  logic        done_q;
  logic [63:0] product_q;
  logic [63:0] step_val;

  // Carry-out becomes the new top bit of the shifted partial product, so the
  // 33rd sum bit is never lost.
  assign step_val = {alu_cout, alu_r, p_lo_q[31:1]};

  assign alu_a          = p_hi_q;
  assign alu_b          = p_lo_q[0] ? mcand_q : '0;
  assign alu_cin        = 1'b0;
  assign alu_cless_than = 1'b0;
  assign alu_op         = ALU_OP_ADD;

  assign busy    = (state_q == RUN);
  assign done    = done_q;
  assign product = product_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (cnt_q == LAST_CNT) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      p_hi_q    <= '0;
      p_lo_q    <= '0;
      mcand_q   <= '0;
      cnt_q     <= '0;
      done_q    <= 1'b0;
      product_q <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            mcand_q <= multiplicand;
            p_hi_q  <= '0;
            p_lo_q  <= multiplier;
            cnt_q   <= '0;
          end
        end
        RUN: begin
          {p_hi_q, p_lo_q} <= step_val;
          cnt_q            <= cnt_q + 5'd1;
          if (cnt_q == LAST_CNT) begin
            done_q    <= 1'b1;
            product_q <= step_val;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
